// File: rtl/tft_de_receiver_pkg.sv
// ---------------------------------------------------------------------------
// tft_de_receiver_pkg
// Shared constants for the 480x272 DE-mode TFT interface (driver and
// receiver side), the receiver FSM state encoding and the per-pixel
// checksum term.
// ---------------------------------------------------------------------------
package tft_de_receiver_pkg;

    localparam int H_ACTIVE  = 480;   // active pixels per line
    localparam int V_ACTIVE  = 272;   // active lines per frame
    localparam int VB_THRESH = 1000;  // DE-low samples that mark a vertical blank
    localparam int BLANK_W   = 16;    // width of the saturating blank counter
    localparam int RGB_W     = 24;    // {R[7:0], G[7:0], B[7:0]}
    localparam int CKSUM_W   = 16;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_VBLANK   = 2'd1,
        ST_ACTIVE   = 2'd2,
        ST_HBLANK   = 2'd3
    } state_e;

    // Zero-extended R+G+B, the quantity the frame checksum accumulates.
    function automatic logic [CKSUM_W-1:0] rgb_sum(input logic [RGB_W-1:0] rgb);
        return {8'd0, rgb[23:16]} + {8'd0, rgb[15:8]} + {8'd0, rgb[7:0]};
    endfunction

endpackage

// File: rtl/tft_de_receiver_cksum.sv
// ---------------------------------------------------------------------------
// tft_rx_cksum
// Frame checksum accumulator: running 16-bit sum of R+G+B of the emitted
// pixels, latched into 'checksum' at the end of each frame.
//   Clk, rst   : clock, asynchronous active-high reset
//   clr        : restart the sum (first pixel of a frame)
//   add_en     : add rgb to the sum (pixel emitted this cycle)
//   rgb        : pixel data
//   latch      : copy the running sum to 'checksum' (frame end)
//   checksum   : last latched frame checksum
// ---------------------------------------------------------------------------
module tft_rx_cksum
    import tft_de_receiver_pkg::*;
(
    input  logic               Clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               add_en,
    input  logic [RGB_W-1:0]   rgb,
    input  logic               latch,
    output logic [CKSUM_W-1:0] checksum
);

    logic [CKSUM_W-1:0] acc;

    // NOTE: registers are written with non-blocking assignments so every
    // flop samples the pre-edge value of every other flop.
    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            acc      <= '0;
            checksum <= '0;
        end else begin
            // A clear coincides with the first pixel, which seeds the sum.
            if (clr) begin
                acc <= add_en ? rgb_sum(rgb) : '0;
            end else if (add_en) begin
                acc <= acc + rgb_sum(rgb);
            end
            if (latch) begin
                checksum <= acc;
            end
        end
    end

endmodule

// File: rtl/tft_de_receiver.sv
// ---------------------------------------------------------------------------
// tft_de_receiver
// Panel-side receiver for the DE-mode RGB interface. Locks onto the first
// vertical blank, recovers pixel coordinates and frame/line markers, sums a
// per-frame checksum and flags line-length and frame-height violations.
//   Clk, rst       : system clock, asynchronous active-high reset
//   pix_ce         : one-Clk pixel strobe; all tracking advances only on it
//   de_in, rgb_in  : data enable and pixel data from the driver
//   err_clr        : clears the sticky error flags (a new error wins)
//   locked         : a vertical blank has been seen, frames are tracked
//   pix_valid      : emitted pixel strobe, with pix_rgb / x / y / sof / eol
//   frame_done     : one-Clk pulse at end of frame; checksum updates with it
//   line_len_err   : sticky, a line did not carry H_ACTIVE pixels
//   frame_hgt_err  : sticky, a frame did not carry V_ACTIVE lines
// ---------------------------------------------------------------------------
module tft_de_receiver
    import tft_de_receiver_pkg::*;
#(
    parameter int H_ACTIVE  = tft_de_receiver_pkg::H_ACTIVE,
    parameter int V_ACTIVE  = tft_de_receiver_pkg::V_ACTIVE,
    parameter int VB_THRESH = tft_de_receiver_pkg::VB_THRESH,
    parameter int BLANK_W   = tft_de_receiver_pkg::BLANK_W
) (
    input  logic               Clk,
    input  logic               rst,
    input  logic               pix_ce,
    input  logic               de_in,
    input  logic [RGB_W-1:0]   rgb_in,
    input  logic               err_clr,
    output logic               locked,
    output logic               pix_valid,
    output logic [RGB_W-1:0]   pix_rgb,
    output logic [9:0]         x,
    output logic [8:0]         y,
    output logic               sof,
    output logic               eol,
    output logic               frame_done,
    output logic [CKSUM_W-1:0] checksum,
    output logic               line_len_err,
    output logic               frame_hgt_err
);

    localparam logic [10:0]        H_LEN  = 11'(H_ACTIVE);
    localparam logic [10:0]        H_LAST = 11'(H_ACTIVE - 1);
    localparam logic [9:0]         V_LEN  = 10'(V_ACTIVE);
    localparam logic [BLANK_W-1:0] VB_LIM = BLANK_W'(VB_THRESH);

    state_e             state;
    logic [BLANK_W-1:0] blank_cnt, blank_next;
    // col/row keep counting past the active area so the length and height
    // checks see the true totals; they only saturate at their own width.
    logic [10:0]        col, pix_col, col_next;
    logic [9:0]         row, row_inc, pix_row;
    logic               vb_hit, start, new_line, in_line, line_end, frame_end;
    logic               emit, len_bad, hgt_bad;

    // NOTE: every signal gets a value on every path through this block,
    // so no latches are inferred.
    always_comb begin
        blank_next = de_in ? '0 : ((blank_cnt == '1) ? blank_cnt : blank_cnt + 1'b1);
        vb_hit     = !de_in && (blank_next >= VB_LIM);
        row_inc    = (row == '1) ? row : row + 1'b1;

        start      = pix_ce && de_in && (state == ST_VBLANK);
        new_line   = pix_ce && de_in && (state == ST_HBLANK) && (blank_cnt < VB_LIM);
        in_line    = pix_ce && de_in && (state == ST_ACTIVE);
        line_end   = pix_ce && !de_in && (state == ST_ACTIVE);
        frame_end  = pix_ce && vb_hit && (state == ST_HBLANK);

        // Coordinates of the pixel carried by this sample.
        pix_col    = (start || new_line) ? '0 : col;
        pix_row    = start ? '0 : (new_line ? row_inc : row);
        col_next   = (pix_col == '1) ? pix_col : pix_col + 1'b1;

        emit       = (start || new_line || in_line) && (pix_col < H_LEN) && (pix_row < V_LEN);
        len_bad    = line_end && (col != H_LEN);
        // row is the index of the last line, so lines seen = row + 1.
        hgt_bad    = frame_end && (row_inc != V_LEN);
    end

    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            state         <= ST_UNLOCKED;
            locked        <= 1'b0;
            blank_cnt     <= '0;
            col           <= '0;
            row           <= '0;
            pix_valid     <= 1'b0;
            pix_rgb       <= '0;
            x             <= '0;
            y             <= '0;
            sof           <= 1'b0;
            eol           <= 1'b0;
            frame_done    <= 1'b0;
            line_len_err  <= 1'b0;
            frame_hgt_err <= 1'b0;
        end else begin
            // Strobes are qualified by pix_ce inside emit/start/frame_end,
            // so they drop to 0 on every non-enable cycle.
            pix_valid     <= emit;
            sof           <= start;
            eol           <= emit && (pix_col == H_LAST);
            frame_done    <= frame_end;
            line_len_err  <= len_bad || (line_len_err && !err_clr);
            frame_hgt_err <= hgt_bad || (frame_hgt_err && !err_clr);

            if (emit) begin
                pix_rgb <= rgb_in;
                x       <= pix_col[9:0];
                y       <= pix_row[8:0];
            end

            if (pix_ce) begin
                blank_cnt <= blank_next;
                if (start || new_line || in_line) begin
                    col <= col_next;
                    row <= pix_row;
                end
                case (state)
                    ST_UNLOCKED: if (vb_hit) begin
                        state  <= ST_VBLANK;
                        locked <= 1'b1;
                    end
                    // A DE pulse before the blank threshold is still a frame start.
                    ST_VBLANK:   if (de_in) state <= ST_ACTIVE;
                    ST_ACTIVE:   if (!de_in) state <= ST_HBLANK;
                    ST_HBLANK: begin
                        if (new_line) begin
                            state <= ST_ACTIVE;
                        end else if (frame_end) begin
                            state <= ST_VBLANK;
                        end
                    end
                    default:     state <= ST_UNLOCKED;
                endcase
            end
        end
    end

    tft_rx_cksum u_cksum (
        .Clk      (Clk),
        .rst      (rst),
        .clr      (start),
        .add_en   (emit),
        .rgb      (rgb_in),
        .latch    (frame_end),
        .checksum (checksum)
    );

endmodule
